// File: rtl/icebreaker_ledctl_if.sv
// Button/LED bundle for icebreaker_ledctl: raw buttons in, pattern, mode and step pulse out.
interface icebreaker_ledctl_if #(
    parameter int BITS = 5
);
    logic [3:0]      btn;
    logic [BITS-1:0] leds;
    logic [1:0]      led_mode;
    logic            tick;

    modport master (output btn, input leds, led_mode, tick);
    modport slave  (input btn, output leds, led_mode, tick);
endinterface

// File: rtl/icebreaker_ledctl.sv
// LED pattern controller: debounced buttons select mode/run/direction of a stepped pattern.
// Define ICEBREAKER_LEDCTL_PWM_EN to add btn[3]-controlled PWM brightness gating.
module icebreaker_ledctl #(
    parameter int BITS      = 5,
    parameter int LOG2DELAY = 22,
    parameter int DEB_LOG2  = 16
) (
    input logic               clk,
    input logic               rst,
    icebreaker_ledctl_if.slave io
);
`ifdef ICEBREAKER_LEDCTL_PWM_EN
    localparam int NBTN = 4;
`else
    localparam int NBTN = 3;
`endif
    localparam int IW = $clog2(BITS);
    localparam logic [IW-1:0] IDX_MAX = IW'(BITS - 1);

    typedef enum logic [1:0] {
        MODE_GRAY   = 2'd0,
        MODE_BINARY = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    mode_t mode_q, mode_d;

    logic [NBTN-1:0]     sync1, sync2, stable, press;
    logic [DEB_LOG2-1:0] deb_cnt [NBTN];

    logic [LOG2DELAY-1:0] pre;
    logic                 run, dir, bounce, tick_q, step;
    logic [BITS-1:0]      pos, pattern, gated, leds_q;
    logic [IW-1:0]        idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int unsigned i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= io.btn[NBTN-1:0];
            sync2 <= sync1;
            for (int unsigned i = 0; i < NBTN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (&deb_cnt[i]) begin
                    // Only a settled rising edge becomes a press; releases just update stable.
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                    press[i]   <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign step = run && (&pre);

    always_comb begin
        mode_d = mode_q;
        if (press[0]) begin
            case (mode_q)
                MODE_GRAY:   mode_d = MODE_BINARY;
                MODE_BINARY: mode_d = MODE_SCAN;
                MODE_SCAN:   mode_d = MODE_BLINK;
                default:     mode_d = MODE_GRAY;
            endcase
        end
    end

    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_GRAY:   pattern = pos ^ (pos >> 1);
            MODE_BINARY: pattern = pos;
            MODE_SCAN:   pattern[idx] = 1'b1;
            default:     pattern = {BITS{pos[0]}};
        endcase
    end

`ifdef ICEBREAKER_LEDCTL_PWM_EN
    logic [2:0] level, pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 3'd7;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (press[3]) level <= level + 1'b1;
        end
    end

    assign gated = (pwm_cnt <= level) ? pattern : '0;
`else
    assign gated = pattern;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_GRAY;
            pre    <= '0;
            tick_q <= 1'b0;
            run    <= 1'b1;
            dir    <= 1'b0;
            bounce <= 1'b0;
            pos    <= '0;
            idx    <= '0;
            leds_q <= '0;
        end else begin
            mode_q <= mode_d;
            tick_q <= step;
            leds_q <= gated;
            if (run) pre <= pre + 1'b1;
            if (press[1]) run <= ~run;
            if (press[2]) dir <= ~dir;
            // step sees dir before any same-cycle toggle
            if (step) begin
                pos <= dir ? pos - 1'b1 : pos + 1'b1;
                if (!bounce) begin
                    if (idx == IDX_MAX) begin
                        idx    <= idx - 1'b1;
                        bounce <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    if (idx == '0) begin
                        idx    <= idx + 1'b1;
                        bounce <= 1'b0;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
            end
        end
    end

    assign io.leds     = leds_q;
    assign io.led_mode = mode_q;
    assign io.tick     = tick_q;
endmodule
